// File: rtl/ram_write_queue.sv
// Circular store queue feeding one blockram write port, with store-to-load
// forwarding from queued and in-flight stores and a drain-all flush handshake.
module ram_write_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_address,
    input  logic [DATA_W-1:0] in_value,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              mem_grant,
    output logic              write_enabled,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_value,
    output logic              done_valid,
    output logic [TAG_W-1:0]  done_tag,
    input  logic [ADDR_W-1:0] lookup_address,
    output logic              lookup_hit,
    output logic [DATA_W-1:0] lookup_value,
    input  logic              flush_req,
    output logic              flush_done
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    logic              queue_hit;
    logic [DATA_W-1:0] queue_value;
    logic [PTR_W-1:0]  scan_idx;
    logic              inflight_hit;

    // A full queue never accepts, even if a pop frees a slot on the same edge.
    assign in_ready = !rst && (state == RUN) && (count < FULL_COUNT);
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && mem_grant;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= in_address;
            data_mem[tail] <= in_value;
            tag_mem[tail]  <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Write port and completion report are registered copies of the popped head.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_enabled <= 1'b0;
            write_address <= '0;
            write_value   <= '0;
            done_valid    <= 1'b0;
            done_tag      <= '0;
        end else begin
            write_enabled <= pop;
            done_valid    <= pop;
            if (pop) begin
                write_address <= addr_mem[head];
                write_value   <= data_mem[head];
                done_tag      <= tag_mem[head];
            end
        end
    end

    // Flush completes only once the queue is empty and the last write has left.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (flush_req) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if ((count == '0) && !write_enabled) begin
                        state      <= RUN;
                        flush_done <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Scan oldest to youngest so the youngest matching entry wins.
    always_comb begin
        queue_hit   = 1'b0;
        queue_value = '0;
        scan_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (addr_mem[scan_idx] == lookup_address)) begin
                queue_hit   = 1'b1;
                queue_value = data_mem[scan_idx];
            end
        end
    end

    assign inflight_hit = write_enabled && (write_address == lookup_address);
    assign lookup_hit   = queue_hit || inflight_hit;
    assign lookup_value = queue_hit    ? queue_value :
                          inflight_hit ? write_value : '0;

endmodule

// File: tb/tb_ram_write_queue.sv
// Self-checking bench for ram_write_queue: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_ram_write_queue;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_address;
    logic [DATA_W-1:0] in_value;
    logic [TAG_W-1:0]  in_tag;
    logic              mem_grant;
    logic              write_enabled;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_value;
    logic              done_valid;
    logic [TAG_W-1:0]  done_tag;
    logic [ADDR_W-1:0] lookup_address;
    logic              lookup_hit;
    logic [DATA_W-1:0] lookup_value;
    logic              flush_req;
    logic              flush_done;

    ram_write_queue #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_address(in_address), .in_value(in_value), .in_tag(in_tag),
        .mem_grant(mem_grant),
        .write_enabled(write_enabled), .write_address(write_address),
        .write_value(write_value),
        .done_valid(done_valid), .done_tag(done_tag),
        .lookup_address(lookup_address), .lookup_hit(lookup_hit),
        .lookup_value(lookup_value),
        .flush_req(flush_req), .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        logic [TAG_W-1:0]  t;
    } entry_t;

    entry_t            mq[$];
    logic              m_flush, m_we, m_done, m_fd;
    logic [ADDR_W-1:0] m_wa;
    logic [DATA_W-1:0] m_wv;
    logic [TAG_W-1:0]  m_dt;
    int                checks = 0;
    int                failures = 0;
    bit                compare_on = 1'b0;

    task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: one step per rising edge, using the inputs held across it.
    task automatic modelStep();
        bit     ready, popping, fd_next;
        entry_t e;
        if (rst) begin
            mq.delete();
            m_flush = 0; m_we = 0; m_done = 0; m_fd = 0;
            m_wa = '0; m_wv = '0; m_dt = '0;
        end else begin
            ready   = !m_flush && (mq.size() < DEPTH);
            popping = (mq.size() > 0) && mem_grant;
            fd_next = m_flush && (mq.size() == 0) && !m_we;
            if (!m_flush && flush_req) m_flush = 1;
            else if (fd_next)          m_flush = 0;
            m_fd = fd_next;
            if (popping) begin
                e = mq.pop_front();
                m_we = 1; m_done = 1; m_wa = e.a; m_wv = e.v; m_dt = e.t;
            end else begin
                m_we = 0; m_done = 0;
            end
            if (in_valid && ready) mq.push_back({in_address, in_value, in_tag});
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    task automatic checkOutput();
        bit                exp_ready, exp_hit;
        logic [DATA_W-1:0] exp_val;
        exp_ready = !rst && !m_flush && (mq.size() < DEPTH);
        exp_hit = 0;
        exp_val = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!exp_hit && mq[i].a == lookup_address) begin
                exp_hit = 1;
                exp_val = mq[i].v;
            end
        end
        if (!exp_hit && m_we && m_wa == lookup_address) begin
            exp_hit = 1;
            exp_val = m_wv;
        end
        expectEq("cyc_in_ready", 32'(in_ready), 32'(exp_ready));
        expectEq("cyc_write_enabled", 32'(write_enabled), 32'(m_we));
        expectEq("cyc_write_address", 32'(write_address), 32'(m_wa));
        expectEq("cyc_write_value", 32'(write_value), 32'(m_wv));
        expectEq("cyc_done_valid", 32'(done_valid), 32'(m_done));
        expectEq("cyc_done_tag", 32'(done_tag), 32'(m_dt));
        expectEq("cyc_flush_done", 32'(flush_done), 32'(m_fd));
        expectEq("cyc_lookup_hit", 32'(lookup_hit), 32'(exp_hit));
        expectEq("cyc_lookup_value", 32'(lookup_value), 32'(exp_val));
    endtask

    always @(negedge clk) begin
        if (compare_on) checkOutput();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                                 input logic g, input logic f);
        in_valid   = v;
        in_address = a;
        in_value   = d;
        in_tag     = t;
        mem_grant  = g;
        flush_req  = f;
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int writes, pulses;
        bit seen;
        rst = 1'b1;
        lookup_address = '0;
        applyStimulus(0, '0, '0, '0, 0, 0);
        tick();
        compare_on = 1'b1;
        tick();
        expectEq("rst_write_enabled", 32'(write_enabled), 0);
        expectEq("rst_done_valid", 32'(done_valid), 0);
        expectEq("rst_in_ready", 32'(in_ready), 0);
        expectEq("rst_lookup_hit", 32'(lookup_hit), 0);
        rst = 1'b0;
        tick();
        expectEq("post_rst_in_ready", 32'(in_ready), 1);

        // Single store: write appears two edges after acceptance, for one cycle.
        applyStimulus(1, 16'd290, 16'd2613, 8'd0, 1, 0);
        tick();
        applyStimulus(0, '0, '0, '0, 1, 0);
        expectEq("lat_no_bypass", 32'(write_enabled), 0);
        tick();
        expectEq("lat_write_enabled", 32'(write_enabled), 1);
        expectEq("lat_write_address", 32'(write_address), 290);
        expectEq("lat_write_value", 32'(write_value), 2613);
        expectEq("lat_done_tag", 32'(done_tag), 0);
        expectEq("lat_done_valid", 32'(done_valid), 1);
        tick();
        expectEq("lat_one_cycle", 32'(write_enabled), 0);
        expectEq("lat_hold_address", 32'(write_address), 290);

        // Fill past full with the port blocked, then drain in order.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, ADDR_W'(1000 + i), DATA_W'(i), TAG_W'(i), 0, 0);
            tick();
        end
        expectEq("full_in_ready", 32'(in_ready), 0);
        applyStimulus(0, '0, '0, '0, 1, 0);
        tick();
        expectEq("full_ready_after_pop", 32'(in_ready), 1);
        for (int k = 0; k < 8; k++) begin
            expectEq("drain_we", 32'(write_enabled), 1);
            expectEq("drain_order", 32'(write_address), 32'(1000 + k));
            tick();
        end
        expectEq("drain_end", 32'(write_enabled), 0);

        // Forwarding picks the youngest match.
        applyStimulus(1, 16'd100, 16'h000A, 8'd1, 0, 0); tick();
        applyStimulus(1, 16'd212, 16'h000B, 8'd2, 0, 0); tick();
        applyStimulus(1, 16'd100, 16'h000C, 8'd3, 0, 0); tick();
        applyStimulus(0, '0, '0, '0, 0, 0);
        lookup_address = 16'd100; tick();
        expectEq("fwd100_hit", 32'(lookup_hit), 1);
        expectEq("fwd100_value", 32'(lookup_value), 32'h0C);
        lookup_address = 16'd212; tick();
        expectEq("fwd212_value", 32'(lookup_value), 32'h0B);
        lookup_address = 16'd101; tick();
        expectEq("fwd101_hit", 32'(lookup_hit), 0);
        expectEq("fwd101_value", 32'(lookup_value), 0);

        // Flush three queued entries with a toggling grant.
        applyStimulus(0, '0, '0, '0, 0, 1);
        tick();
        flush_req = 1'b0;
        writes = 0; pulses = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            mem_grant = (c % 2 == 0);
            tick();
            if (write_enabled) writes++;
            if (flush_done) seen = 1;
            else expectEq("flush_in_ready", 32'(in_ready), 0);
        end
        expectEq("flush_seen", 32'(seen), 1);
        expectEq("flush_writes", 32'(writes), 3);
        expectEq("flush_ready_back", 32'(in_ready), 1);
        tick();
        expectEq("flush_single_pulse", 32'(flush_done), 0);

        // Flush with an empty queue completes on the following cycle.
        applyStimulus(0, '0, '0, '0, 0, 1);
        tick();
        flush_req = 1'b0;
        expectEq("eflush_in_ready", 32'(in_ready), 0);
        tick();
        expectEq("eflush_done", 32'(flush_done), 1);

        // Reset with five entries queued and a write in flight.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, ADDR_W'(3000 + i), DATA_W'(i), TAG_W'(i), 0, 0);
            tick();
        end
        applyStimulus(0, '0, '0, '0, 1, 0);
        tick();
        expectEq("rstmid_inflight", 32'(write_enabled), 1);
        rst = 1'b1;
        lookup_address = 16'd3002;
        tick();
        expectEq("rstmid_we", 32'(write_enabled), 0);
        expectEq("rstmid_done", 32'(done_valid), 0);
        expectEq("rstmid_hit", 32'(lookup_hit), 0);
        rst = 1'b0;
        tick();
        expectEq("rstmid_empty", 32'(write_enabled), 0);

        // Steady state at count 3 with push and pop on every edge.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, ADDR_W'(2000 + i), DATA_W'(i), TAG_W'(i), 0, 0);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, ADDR_W'(2003 + k), DATA_W'(k), TAG_W'(k), 1, 0);
            expectEq("steady_in_ready", 32'(in_ready), 1);
            tick();
            expectEq("steady_order", 32'(write_address), 32'(2000 + k));
        end
        applyStimulus(0, '0, '0, '0, 1, 0);
        repeat (6) tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 700; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 15)),
                          DATA_W'($urandom), TAG_W'($urandom), $urandom_range(0, 2) != 0,
                          $urandom_range(0, 39) == 0);
            lookup_address = ADDR_W'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        applyStimulus(0, '0, '0, '0, 1, 0);
        repeat (DEPTH + 4) tick();
        compare_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
